// File: rtl/dqn_train_sequencer.sv
// Training-step sequencer: walks controller phases CTRL_FIRST..CTRL_LAST for each of n_steps steps.
// Registered step/controller/done; hold freezes progress, abort returns to IDLE without done.
module dqn_train_sequencer #(
  parameter logic [3:0] CTRL_FIRST = 4'd4,
  parameter logic [3:0] CTRL_LAST  = 4'd9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] n_steps,
  input  logic       hold,
  input  logic       abort,
  output logic [3:0] step,
  output logic [3:0] controller,
  output logic       upd_en,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] n_lat;

  assign busy   = (state == RUN);
  assign upd_en = busy && (controller == CTRL_LAST) && !hold;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      step       <= 4'd0;
      controller <= 4'd0;
      n_lat      <= 4'd0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // abort outranks start even while idle, so a coincident pair never launches a run
          if (start && !abort) begin
            if (n_steps != 4'd0) begin
              n_lat      <= n_steps;
              step       <= 4'd1;
              controller <= CTRL_FIRST;
              state      <= RUN;
            end else begin
              n_lat <= 4'd0;
              state <= FIN;
              done  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (abort) begin
            state      <= IDLE;
            step       <= 4'd0;
            controller <= 4'd0;
          end else if (!hold) begin
            if (controller != CTRL_LAST) begin
              controller <= controller + 4'd1;
            end else if (step < n_lat) begin
              step       <= step + 4'd1;
              controller <= CTRL_FIRST;
            end else begin
              state      <= FIN;
              step       <= 4'd0;
              controller <= 4'd0;
              done       <= 1'b1;
            end
          end
        end
        FIN: begin
          state      <= IDLE;
          step       <= 4'd0;
          controller <= 4'd0;
        end
        default: begin
          state      <= IDLE;
          step       <= 4'd0;
          controller <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: doc/dqn_train_sequencer.md
DQN_TRAIN_SEQUENCER -- requirements
Module: dqn_train_sequencer

Interface
REQ-001 Parameter CTRL_FIRST, default 4: first controller phase code of each training step.
REQ-002 Parameter CTRL_LAST, default 9: last controller phase code, the weight-capture phase; CTRL_LAST > CTRL_FIRST, both 4-bit.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-low.
REQ-005 start  input  1  request a training run; sampled only in IDLE.
REQ-006 n_steps  input  4  number of steps in the run; latched on accepted start.
REQ-007 hold  input  1  freeze step/controller for this cycle (datapath stall).
REQ-008 abort  input  1  synchronous cancel of the current run.
REQ-009 step  output  4  current step index, registered; 0 when not running.
REQ-010 controller  output  4  current phase code, registered; 0 when not running.
REQ-011 upd_en  output  1  weight-update strobe.
REQ-012 busy  output  1  high while in RUN.
REQ-013 done  output  1  one-cycle run-complete pulse, registered.

Function
REQ-014 The FSM SHALL have states IDLE, RUN, FIN, encoded in registers.
REQ-015 IDLE: start=1 with n_steps!=0 SHALL latch n_steps and, at the same edge, load step=1 and controller=CTRL_FIRST, then enter RUN.
REQ-016 IDLE: start=1 with n_steps=0 SHALL enter FIN directly, leaving step and controller at 0.
REQ-017 RUN, hold=0, controller<CTRL_LAST: controller SHALL increment by 1 at the next edge; step unchanged.
REQ-018 RUN, hold=0, controller=CTRL_LAST, step<latched n_steps: next edge SHALL load step+1 and controller=CTRL_FIRST.
REQ-019 RUN, hold=0, controller=CTRL_LAST, step=latched n_steps: next edge SHALL enter FIN with step=0, controller=0.
REQ-020 RUN, hold=1: step, controller and state SHALL remain unchanged.
REQ-021 upd_en SHALL be combinational and high only in RUN with controller=CTRL_LAST and hold=0.
REQ-022 FIN SHALL last exactly one cycle, with done=1 during it, then return to IDLE; done SHALL be 0 in all other cycles.
REQ-023 busy SHALL equal (state==RUN).
REQ-024 abort=1 in RUN or FIN SHALL force IDLE, step=0, controller=0 at the next edge with no done pulse; abort SHALL take priority over hold and start.
REQ-025 start asserted outside IDLE SHALL be ignored and SHALL NOT be queued.
REQ-026 Changes on n_steps after acceptance SHALL NOT affect the running sequence.
REQ-027 Run length with no hold SHALL be n_steps*(CTRL_LAST-CTRL_FIRST+1) RUN cycles, followed by one FIN cycle.
REQ-028 step SHALL never exceed the latched n_steps; no wrap-around is permitted (maximum 15).

Reset
REQ-029 While rst=0, regardless of clk: state=IDLE, step=0, controller=0, busy=0, done=0, upd_en=0, latched n_steps=0.
REQ-030 rst asserted mid-run SHALL abandon the run immediately; after release, the block SHALL wait in IDLE for a new start.
REQ-031 The first rising edge after rst deassertion SHALL sample inputs normally.

Verification
REQ-032 Run of 2: n_steps=2, start pulse -> controller 4,5,6,7,8,9 with step=1, then 4..9 with step=2; upd_en in those 2 controller=9 cycles; done at cycle 13 after start; then IDLE.
REQ-033 Hold: n_steps=1, hold=1 for 3 cycles while controller=6 -> controller stays 6 for 3 cycles; upd_en=0 while held; done arrives 3 cycles later than with no hold.
REQ-034 Zero steps: n_steps=0, start -> busy never asserts; done pulses the cycle after start; step and controller stay 0.
REQ-035 Abort: n_steps=3, abort at step=2, controller=7 -> next cycle IDLE, step=0, controller=0; no done and no further upd_en.
REQ-036 Ignored start: start re-pulsed at step=1, controller=5 with n_steps changed to 9 -> sequence unaffected; run ends after the originally latched count.
REQ-037 Async reset: rst=0 between clock edges at step=1, controller=8 -> outputs zero immediately without a clock edge; after release, start with n_steps=1 runs normally.
